// File: rtl/branch_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// branch_ctrl_pkg
// Shared definitions for the branch controller and the decode-stage condition
// evaluator: condition-code encodings, flag bit positions, FSM states,
// default widths and a saturating counter helper.
// ----------------------------------------------------------------------------
package branch_ctrl_pkg;

   localparam int ADDR_W_DEF       = 16;
   localparam int FLUSH_CYCLES_DEF = 2;
   localparam int CC_W             = 6;
   localparam int COND_W           = 3;
   localparam int CNT_W            = 8;

   // Condition codes carried by br_cond. The six real codes equal the flag
   // bit index they select; the two top codes never take.
   typedef enum logic [COND_W-1:0] {
      COND_LT  = 3'b000,
      COND_GT  = 3'b001,
      COND_LE  = 3'b010,
      COND_GE  = 3'b011,
      COND_EQ  = 3'b100,
      COND_NE  = 3'b101,
      COND_NV0 = 3'b110,
      COND_NV1 = 3'b111
   } cond_e;

   // Flag bit positions inside cc_in / cc_reg: {NE,EQ,GE,LE,GT,LT}.
   localparam int CC_LT = 0;
   localparam int CC_GT = 1;
   localparam int CC_LE = 2;
   localparam int CC_GE = 3;
   localparam int CC_EQ = 4;
   localparam int CC_NE = 5;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_CC  = 2'd1,
      REDIRECT = 2'd2,
      FLUSH    = 2'd3
   } state_e;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// ----------------------------------------------------------------------------
// branch_cond_eval
// Purely combinational branch condition evaluator.
//   cond  : 3-bit condition code (see cond_e)
//   flags : 6-bit flag vector {NE,EQ,GE,LE,GT,LT}
//   taken : 1 when the selected flag is set; codes 110/111 never take
// ----------------------------------------------------------------------------
module branch_cond_eval
   import branch_ctrl_pkg::*;
(
   input  logic [COND_W-1:0] cond,
   input  logic [CC_W-1:0]   flags,
   output logic              taken
);

   always_comb begin
      // NOTE: assign a default before the case so no path leaves taken
      // unassigned; otherwise synthesis infers a latch.
      taken = 1'b0;
      case (cond_e'(cond))
         COND_LT: taken = flags[CC_LT];
         COND_GT: taken = flags[CC_GT];
         COND_LE: taken = flags[CC_LE];
         COND_GE: taken = flags[CC_GE];
         COND_EQ: taken = flags[CC_EQ];
         COND_NE: taken = flags[CC_NE];
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/branch_ctrl.sv
// ----------------------------------------------------------------------------
// branch_ctrl
// Resolves decode-stage branches and jumps, waits for in-flight flags when
// needed, issues a redirect to fetch and squashes younger instructions.
//   clk, rst            : clock, asynchronous active-low reset
//   br_valid/br_is_jump : branch (or unconditional jump) present in decode
//   br_cond, br_target  : condition code and target address
//   cc_valid, cc_in     : new flags written by execute this cycle
//   cc_pending          : a flag writer is in flight, flags not yet valid
//   fetch_ready         : fetch accepts the redirect this cycle
//   stall               : hold fetch and decode
//   redirect_valid/_pc  : redirect request and address
//   flush               : squash younger instructions
//   resolved            : pulse when a branch decision is made
//   taken_cnt           : saturating count of redirects issued
// FLUSH_CYCLES must lie in 1..7 (3-bit down-counter).
// ----------------------------------------------------------------------------
module branch_ctrl
   import branch_ctrl_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              br_valid,
   input  logic              br_is_jump,
   input  logic [COND_W-1:0] br_cond,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              cc_valid,
   input  logic [CC_W-1:0]   cc_in,
   input  logic              cc_pending,
   input  logic              fetch_ready,
   output logic              stall,
   output logic              redirect_valid,
   output logic [ADDR_W-1:0] redirect_pc,
   output logic              flush,
   output logic              resolved,
   output logic [CNT_W-1:0]  taken_cnt
);

   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   state_e            state;
   logic [CC_W-1:0]   cc_reg;
   logic [ADDR_W-1:0] target_q;
   logic [COND_W-1:0] cond_q;
   logic [2:0]        flush_cnt;

   logic [CC_W-1:0]   flags_eff;
   logic [COND_W-1:0] cond_sel;
   logic              taken;
   logic              idle_jump, idle_cond, idle_wait, idle_eval, wait_eval;

   // Same-cycle bypass: fresh flags from execute win over the stored copy.
   assign flags_eff = cc_valid ? cc_in : cc_reg;
   // While waiting, evaluate the latched condition; otherwise the live one.
   assign cond_sel  = (state == WAIT_CC) ? cond_q : br_cond;

   branch_cond_eval u_eval (
      .cond  (cond_sel),
      .flags (flags_eff),
      .taken (taken)
   );

   assign idle_jump = (state == IDLE) && br_valid && br_is_jump;
   assign idle_cond = (state == IDLE) && br_valid && !br_is_jump;
   assign idle_wait = idle_cond && cc_pending && !cc_valid;
   assign idle_eval = idle_cond && !idle_wait;
   assign wait_eval = (state == WAIT_CC) && cc_valid;

   // The input-dependent terms are gated by rst so every output is quiet
   // while reset is held, whatever decode presents.
   assign resolved       = rst && (idle_jump || idle_eval || wait_eval);
   assign stall          = (state == WAIT_CC) || (state == REDIRECT) || (rst && idle_wait);
   assign redirect_valid = (state == REDIRECT);
   assign redirect_pc    = target_q;
   assign flush          = (state == REDIRECT) || (state == FLUSH);

   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cc_reg    <= '0;
         target_q  <= '0;
         cond_q    <= '0;
         flush_cnt <= '0;
         taken_cnt <= '0;
      end else begin
         if (cc_valid) cc_reg <= cc_in;

         case (state)
            IDLE: begin
               if (idle_jump || (idle_eval && taken)) begin
                  target_q  <= br_target;
                  taken_cnt <= sat_inc(taken_cnt);
                  state     <= REDIRECT;
               end else if (idle_wait) begin
                  target_q <= br_target;
                  cond_q   <= br_cond;
                  state    <= WAIT_CC;
               end
            end
            WAIT_CC: begin
               if (cc_valid) begin
                  if (taken) begin
                     taken_cnt <= sat_inc(taken_cnt);
                     state     <= REDIRECT;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            REDIRECT: begin
               if (fetch_ready) begin
                  flush_cnt <= FLUSH_LOAD;
                  state     <= FLUSH;
               end
            end
            FLUSH: begin
               if (flush_cnt == 3'd0) state <= IDLE;
               else                   flush_cnt <= flush_cnt - 3'd1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_branch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_branch_ctrl
// Self-checking bench for branch_ctrl: a table of single-branch vectors,
// hand-written multi-cycle sequences (pending flags, backpressure, reset in
// FLUSH, counter saturation) and a redirect-address scoreboard.
// ----------------------------------------------------------------------------
module tb_branch_ctrl;

   localparam int AW = 16;
   localparam int FC = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          br_valid = 1'b0;
   logic          br_is_jump = 1'b0;
   logic [2:0]    br_cond = '0;
   logic [AW-1:0] br_target = '0;
   logic          cc_valid = 1'b0;
   logic [5:0]    cc_in = '0;
   logic          cc_pending = 1'b0;
   logic          fetch_ready = 1'b0;
   logic          stall, redirect_valid, flush, resolved;
   logic [AW-1:0] redirect_pc;
   logic [7:0]    taken_cnt;

   int checks = 0;
   int passes = 0;
   logic [AW-1:0] exp_q[$];
   int exp_cnt = 0;

   typedef struct {
      string      name;
      logic       is_jump;
      logic [2:0] cond;
      logic [5:0] preload;
      logic       bypass;
      logic [5:0] cc_now;
      logic [AW-1:0] target;
      logic       exp_taken;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   branch_ctrl #(.ADDR_W(AW), .FLUSH_CYCLES(FC)) dut (
      .clk            (clk),
      .rst            (rst),
      .br_valid       (br_valid),
      .br_is_jump     (br_is_jump),
      .br_cond        (br_cond),
      .br_target      (br_target),
      .cc_valid       (cc_valid),
      .cc_in          (cc_in),
      .cc_pending     (cc_pending),
      .fetch_ready    (fetch_ready),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .resolved       (resolved),
      .taken_cnt      (taken_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Scoreboard: every completed handshake must match the oldest expected target.
   always @(negedge clk) begin
      if (rst && redirect_valid && fetch_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL unexpected_redirect: got pc 0x%0h expected no redirect", redirect_pc);
         end else begin
            check("scoreboard_redirect_pc", redirect_pc, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mk(input string name, input logic is_jump, input logic [2:0] cond,
                               input logic [5:0] preload, input logic bypass, input logic [5:0] cc_now,
                               input logic [AW-1:0] target, input logic exp_taken);
      vec_t v;
      v.name = name; v.is_jump = is_jump; v.cond = cond; v.preload = preload;
      v.bypass = bypass; v.cc_now = cc_now; v.target = target; v.exp_taken = exp_taken;
      return v;
   endfunction

   function automatic int sat(input int v);
      return (v >= 255) ? 255 : v + 1;
   endfunction

   // Called at a negedge; waits (bounded) until the block is quiet, counting flush cycles.
   task automatic drain(input string name, input int exp_flush);
      int n = 0;
      int fl = 0;
      while ((flush || stall || redirect_valid) && n < 20) begin
         if (flush) fl++;
         @(negedge clk);
         n++;
      end
      check({name, "_reached_idle"}, (n < 20), 1);
      check({name, "_flush_cycles"}, fl, exp_flush);
   endtask

   task automatic apply_vec(input vec_t v);
      cc_valid = 1'b1; cc_in = v.preload; br_valid = 1'b0; cc_pending = 1'b0; fetch_ready = 1'b1;
      step();
      br_valid = 1'b1; br_is_jump = v.is_jump; br_cond = v.cond; br_target = v.target;
      cc_valid = v.bypass; cc_in = v.cc_now;
      if (v.exp_taken) begin
         exp_q.push_back(v.target);
         exp_cnt = sat(exp_cnt);
      end
      @(negedge clk);
      check({v.name, "_resolved"}, resolved, 1);
      check({v.name, "_stall"}, stall, 0);
      step();
      br_valid = 1'b0; cc_valid = 1'b0;
      @(negedge clk);
      check({v.name, "_redirect_valid"}, redirect_valid, v.exp_taken);
      drain(v.name, v.exp_taken ? 1 + FC : 0);
      check({v.name, "_taken_cnt"}, taken_cnt, exp_cnt);
   endtask

   initial begin
      int stall_n;

      vecs[0] = mk("jump",        1'b1, 3'b000, 6'b000000, 1'b0, 6'b000000, 16'h0040, 1'b1);
      vecs[1] = mk("eq_bypass",   1'b0, 3'b100, 6'b000000, 1'b1, 6'b010000, 16'h0100, 1'b1);
      vecs[2] = mk("lt_taken",    1'b0, 3'b000, 6'b000001, 1'b0, 6'b000000, 16'h0200, 1'b1);
      vecs[3] = mk("gt_not",      1'b0, 3'b001, 6'b000001, 1'b0, 6'b000000, 16'h0300, 1'b0);
      vecs[4] = mk("le_taken",    1'b0, 3'b010, 6'b000100, 1'b0, 6'b000000, 16'h0400, 1'b1);
      vecs[5] = mk("ge_not",      1'b0, 3'b011, 6'b110111, 1'b0, 6'b000000, 16'h0500, 1'b0);
      vecs[6] = mk("ne_taken",    1'b0, 3'b101, 6'b100000, 1'b0, 6'b000000, 16'hfffe, 1'b1);
      vecs[7] = mk("nv110",       1'b0, 3'b110, 6'b111111, 1'b0, 6'b000000, 16'h0700, 1'b0);
      vecs[8] = mk("nv111",       1'b0, 3'b111, 6'b111111, 1'b0, 6'b000000, 16'h0800, 1'b0);
      vecs[9] = mk("bypass_over", 1'b0, 3'b000, 6'b000001, 1'b1, 6'b000000, 16'h0900, 1'b0);

      // Reset: outputs quiet even with a jump presented.
      br_valid = 1'b1; br_is_jump = 1'b1; br_target = 16'h1111;
      #2;
      check("reset_stall", stall, 0);
      check("reset_redirect_valid", redirect_valid, 0);
      check("reset_redirect_pc", redirect_pc, 0);
      check("reset_flush", flush, 0);
      check("reset_resolved", resolved, 0);
      check("reset_taken_cnt", taken_cnt, 0);
      step(); step();
      br_valid = 1'b0; br_is_jump = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("post_reset_redirect_valid", redirect_valid, 0);

      foreach (vecs[i]) apply_vec(vecs[i]);

      // Pending flags, not taken: 5 stall cycles, resolved on the 5th.
      cc_valid = 1'b1; cc_in = 6'b000001;
      step();
      stall_n = 0;
      br_valid = 1'b1; br_is_jump = 1'b0; br_cond = 3'b000; br_target = 16'h2222;
      cc_valid = 1'b0; cc_pending = 1'b1;
      @(negedge clk);
      check("pend_first_resolved", resolved, 0);
      if (stall) stall_n++;
      for (int i = 0; i < 3; i++) begin
         step();
         br_valid = 1'b1; br_is_jump = 1'b1; br_target = 16'hbad0;
         @(negedge clk);
         check("pend_wait_resolved", resolved, 0);
         check("pend_wait_redirect", redirect_valid, 0);
         if (stall) stall_n++;
      end
      step();
      br_valid = 1'b0; br_is_jump = 1'b0; cc_pending = 1'b0; cc_valid = 1'b1; cc_in = 6'b111110;
      @(negedge clk);
      check("pend_resolved", resolved, 1);
      if (stall) stall_n++;
      step();
      cc_valid = 1'b0;
      @(negedge clk);
      if (stall) stall_n++;
      check("pend_no_redirect", redirect_valid, 0);
      check("pend_stall_cycles", stall_n, 5);
      check("pend_taken_cnt", taken_cnt, exp_cnt);

      // Pending flags, taken: latched target survives a changing br_target.
      br_valid = 1'b1; br_cond = 3'b001; br_target = 16'h1234; cc_pending = 1'b1; cc_valid = 1'b0;
      fetch_ready = 1'b1;
      @(negedge clk);
      check("pend2_stall", stall, 1);
      step();
      br_valid = 1'b0; br_target = 16'hffff; cc_pending = 1'b0; cc_valid = 1'b1; cc_in = 6'b000010;
      exp_q.push_back(16'h1234);
      exp_cnt = sat(exp_cnt);
      @(negedge clk);
      check("pend2_resolved", resolved, 1);
      step();
      cc_valid = 1'b0;
      @(negedge clk);
      check("pend2_redirect_valid", redirect_valid, 1);
      drain("pend2", 1 + FC);

      // Backpressure: redirect held 3 cycles, FLUSH only after fetch_ready.
      fetch_ready = 1'b0; br_valid = 1'b1; br_is_jump = 1'b1; br_target = 16'h0abc;
      exp_q.push_back(16'h0abc);
      exp_cnt = sat(exp_cnt);
      step();
      br_valid = 1'b0; br_target = 16'h5555;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_redirect_valid", redirect_valid, 1);
         check("bp_redirect_pc", redirect_pc, 16'h0abc);
         check("bp_stall", stall, 1);
         step();
      end
      fetch_ready = 1'b1;
      @(negedge clk);
      check("bp_ready_redirect_valid", redirect_valid, 1);
      step();
      @(negedge clk);
      check("bp_flush_redirect_valid", redirect_valid, 0);
      check("bp_flush_stall", stall, 0);
      check("bp_flush_flush", flush, 1);
      drain("bp", FC);

      // Reset asserted in FLUSH drops everything at once.
      br_valid = 1'b1; br_is_jump = 1'b1; br_target = 16'h0777;
      exp_q.push_back(16'h0777);
      exp_cnt = sat(exp_cnt);
      step();
      br_valid = 1'b0;
      step();
      @(negedge clk);
      check("rst_pre_flush", flush, 1);
      check("rst_pre_stall", stall, 0);
      br_valid = 1'b1; br_is_jump = 1'b1; br_target = 16'h0999; cc_valid = 1'b1; cc_in = 6'h3f;
      #1 rst = 1'b0;
      #1;
      check("rst_mid_stall", stall, 0);
      check("rst_mid_redirect_valid", redirect_valid, 0);
      check("rst_mid_redirect_pc", redirect_pc, 0);
      check("rst_mid_flush", flush, 0);
      check("rst_mid_resolved", resolved, 0);
      check("rst_mid_taken_cnt", taken_cnt, 0);
      exp_cnt = 0;
      step(); step();
      check("rst_held_flush", flush, 0);
      br_valid = 1'b0; br_is_jump = 1'b0; cc_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("rst_release_flush", flush, 0);
      check("rst_release_redirect_valid", redirect_valid, 0);
      // cc_reg was cleared: GE with no new flags must not take.
      br_valid = 1'b1; br_cond = 3'b011; br_target = 16'h0aaa;
      @(negedge clk);
      check("rst_ccreg_resolved", resolved, 1);
      step();
      br_valid = 1'b0;
      @(negedge clk);
      check("rst_ccreg_redirect_valid", redirect_valid, 0);
      apply_vec(vecs[0]);

      // Saturation: 300 more jumps.
      for (int i = 0; i < 300; i++)
         apply_vec(mk("sat_jump", 1'b1, 3'b000, 6'b000000, 1'b0, 6'b000000, AW'(16'h4000 + i), 1'b1));
      check("sat_taken_cnt", taken_cnt, 255);

      check("scoreboard_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no completion expected finish before 200000");
      $fatal(1);
   end

endmodule
